// File: rtl/seg7_scan_if.sv
// rtl/seg7_scan_if.sv - load handshake between the BCD stage and the 4-digit scanner
interface seg7_scan_if;
    logic [15:0] bcd_in;
    logic [2:0]  int_digits;
    logic        load_req;
    logic        load_ack;

    modport master (
        output bcd_in,
        output int_digits,
        output load_req,
        input  load_ack
    );

    modport slave (
        input  bcd_in,
        input  int_digits,
        input  load_req,
        output load_ack
    );
endinterface

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - 4-digit 7-segment scanner with frame-aligned shadow load (SEG7_LZ_BLANK_EN blanks leading zeros)
module seg7_scan #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_tick
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic          idx_new;
    logic [15:0]   bcd_sh;
    logic [2:0]    int_sh;
    logic [2:0]    int_clamped;
    logic          step;
    logic          boundary;
    logic          lz_blank;
    logic [3:0]    digit;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;

    assign step     = (presc == PMAX);
    assign boundary = step && (idx == 2'd3);
    assign digit    = bcd_sh[{idx, 2'b00} +: 4];

    function automatic logic [6:0] font(input logic [3:0] d);
        case (d)
            4'd0:    font = 7'b1000000;
            4'd1:    font = 7'b1111001;
            4'd2:    font = 7'b0100100;
            4'd3:    font = 7'b0110000;
            4'd4:    font = 7'b0011001;
            4'd5:    font = 7'b0010010;
            4'd6:    font = 7'b0000010;
            4'd7:    font = 7'b1111000;
            4'd8:    font = 7'b0000000;
            4'd9:    font = 7'b0010000;
            default: font = 7'b0111111;
        endcase
    endfunction

    // clamp the requested significant-digit count into 1..4
    always_comb begin
        int_clamped = bus.int_digits;
        if (bus.int_digits == 3'd0) begin
            int_clamped = 3'd1;
        end else if (bus.int_digits > 3'd4) begin
            int_clamped = 3'd4;
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    assign lz_blank = (idx != 2'd0) && ({1'b0, idx} >= int_sh);
`else
    logic unused_int_sh;
    assign lz_blank      = 1'b0;
    assign unused_int_sh = ^int_sh;
`endif

    // prescaler and digit index; idx_new marks the first cycle of each new index (and of post-reset scanning)
    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= '0;
            idx     <= 2'd0;
            idx_new <= 1'b1;
        end else begin
            presc   <= step ? '0 : presc + PW'(1);
            idx_new <= step;
            if (step) begin
                idx <= idx + 2'd1;
            end
        end
    end

    // shadow latch only at frame boundaries so a digit never changes mid-frame
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_sh       <= 16'h0000;
            int_sh       <= 3'd1;
            bus.load_ack <= 1'b0;
            frame_tick   <= 1'b0;
        end else begin
            frame_tick   <= boundary;
            bus.load_ack <= boundary && bus.load_req;
            if (boundary && bus.load_req) begin
                bcd_sh <= bus.bcd_in;
                int_sh <= int_clamped;
            end
        end
    end

    // next display value from the current index and shadows
    always_comb begin
        an_next = 4'b1111;
        if (!lz_blank) begin
            an_next[idx] = 1'b0;
        end
        seg_next = (idx_new || lz_blank) ? 7'b1111111 : font(digit);
    end

    // registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clock cycles each digit stays lit (legal range 2..2^20).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port bcd_in  input  16  four packed BCD digits from the binary-to-BCD stage; [3:0] ones, [15:12] thousands.
REQ-005 SHALL have port int_digits  input  3  count of significant integer digits from the same stage.
REQ-006 SHALL have port load_req  input  1  request to latch bcd_in/int_digits.
REQ-007 SHALL have port load_ack  output  1  one-cycle pulse confirming the latch.
REQ-008 SHALL have port an  output  4  digit enables, active-low; an[0] is the ones digit.
REQ-009 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port frame_tick  output  1  one-cycle pulse at every end of a full 4-digit scan.

Function
REQ-011 SHALL keep a prescaler counting 0..SCAN_DIV-1 and wrapping to 0.
REQ-012 SHALL advance the 2-bit digit index (0->1->2->3->0) in the cycle the prescaler equals SCAN_DIV-1.
REQ-013 SHALL define the frame boundary as the cycle with prescaler = SCAN_DIV-1 and index = 3; frame_tick SHALL be high in the following cycle only.
REQ-014 SHALL hold shadow registers for the 16-bit digits and int_digits; display SHALL come only from shadows, never directly from the inputs.
REQ-015 SHALL latch bcd_in and int_digits into the shadows at a frame boundary when load_req is high, and pulse load_ack for exactly the following cycle.
REQ-016 SHALL ignore load_req outside frame boundaries; a requester holds load_req until load_ack, then drops it; if still high at the next boundary, it re-latches and re-acks.
REQ-017 SHALL clamp shadow int_digits: value 0 stored as 1, values above 4 stored as 4.
REQ-018 SHALL register an and seg, so they reflect the current index and shadows with one cycle of latency; exactly one an bit SHALL be low except while blanked (REQ-020) or in reset.
REQ-019 SHALL decode digits 0-9 to seg: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; codes 10-15 SHALL show a dash, 0111111.
REQ-020 SHALL drive seg=1111111 for the first cycle after every index change, providing one cycle of anti-ghosting blank; an SHALL still follow the index.
REQ-021 SHALL have load_ack and frame_tick coincide when a load is accepted.

Reset
REQ-022 SHALL, while rst is high, force prescaler=0, index=0, shadows=0, int_digits shadow=1, an=1111, seg=1111111, load_ack=0, frame_tick=0.
REQ-023 SHALL treat reset mid-frame or mid-handshake as abort: no load_ack is issued for a pending request, and scanning restarts at index 0 the cycle after rst falls.

Configuration
REQ-024 SHALL, with macro SEG7_LZ_BLANK_EN defined, blank positions whose index ≥ shadow int_digits (an bit high, seg=1111111); the ones digit is never blanked.
REQ-025 SHALL, without SEG7_LZ_BLANK_EN, display all four digits including leading zeros; int_digits SHALL still be latched but is unused.

Verification
REQ-026 SHALL cover: SCAN_DIV=4, rst released, no load -> an sequence 1110,1101,1011,0111 each 4 cycles, seg = 0 pattern (after blank cycle), frame_tick every 16 cycles.
REQ-027 SHALL cover: load_req high with bcd_in=16'h1234, int_digits=4 raised mid-frame -> no change until the boundary; load_ack one cycle with frame_tick; next frame shows 4,3,2,1 on an[0..3].
REQ-028 SHALL cover: bcd_in=16'h0042, int_digits=2 with SEG7_LZ_BLANK_EN -> an[3:2] stay high, seg=1111111 in those slots; without the macro -> 0,0 displayed.
REQ-029 SHALL cover: bcd_in=16'h00A5 -> ones shows 0010010, tens shows dash 0111111.
REQ-030 SHALL cover: rst asserted one cycle before a boundary with load_req high -> no load_ack, shadows=0, an=1111 during reset, scan resumes at an=1110.
REQ-031 SHALL cover: int_digits=0 and int_digits=7 with the macro -> shown as 1 and 4 significant digits respectively.
